regfile_dump_reader: RTL

Sequential reader that walks the architectural register file through one asynchronous read port and streams each register out over a valid/ready interface. It is used for debug dumps, end-of-test state checks and the print path. The block sits beside the register file and owns that file's rs1 read-address port while a dump is in progress. It writes nothing, and the core's write port keeps running during a dump.

---
 rtl/regfile_dump_reader.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/regfile_dump_reader.sv
// Streams registers FIRST_REG..LAST_REG out of the register file over a valid/ready port.
// Optional build macro REGDUMP_CHECKSUM_EN adds a running XOR checksum output.
module regfile_dump_reader #(
  parameter int unsigned FIRST_REG = 0,
  parameter int unsigned LAST_REG  = 31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [4:0]  rf_addr,
  input  logic [31:0] rf_data,
  output logic        busy,
  output logic        done,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_idx,
  output logic [31:0] out_data
`ifdef REGDUMP_CHECKSUM_EN
  ,
  output logic [31:0] checksum
`endif
);

  localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
  localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        out_valid_q, out_valid_d;
  logic [4:0]  out_idx_q, out_idx_d;
  logic [31:0] out_data_q, out_data_d;

  logic handshake;
  logic start_accept;
  logic last_word;

  assign handshake    = out_valid_q & out_ready;
  assign start_accept = (state_q == ST_IDLE) & start;
  assign last_word    = (idx_q == LAST_IDX);

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
    state_d     = state_q;
    idx_d       = idx_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    out_data_d  = out_data_q;
    rf_addr     = 5'd0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          idx_d   = FIRST_IDX;
          busy_d  = 1'b1;
        end
      end

      ST_LOAD: begin
        rf_addr     = idx_q;
        out_data_d  = rf_data;
        out_idx_d   = idx_q;
        out_valid_d = 1'b1;
        state_d     = ST_SEND;
      end

      ST_SEND: begin
        // Look one register ahead so the next word is ready the moment this one is taken.
        rf_addr = idx_q + 5'd1;
        if (handshake) begin
          if (last_word) begin
            rf_addr     = 5'd0;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            state_d     = ST_DONE;
          end else begin
            idx_d      = idx_q + 5'd1;
            out_idx_d  = idx_q + 5'd1;
            out_data_d = rf_data;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= 5'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_idx_q   <= 5'd0;
      out_data_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_data_q  <= out_data_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_data  = out_data_q;

`ifdef REGDUMP_CHECKSUM_EN
  logic [31:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if (start_accept) begin
      checksum_d = 32'd0;
    end else if (handshake) begin
      checksum_d = checksum_q ^ out_data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      checksum_q <= 32'd0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`endif

endmodule
